alu: RTL and testbench
======================

Name: alu

Overview:
- Integer ALU for the RV32I datapath, used in the execute stage.
- Computes a WIDTH-bit result from two operands and a 4-bit select, combinationally (zero latency).
- Also provides a registered copy of the result and flags for pipelines that capture at the stage boundary.

Parameters:
- WIDTH, 32, operand/result width; shift amount uses the low log2(WIDTH) bits of b_val.

Ports:
- clk  input  1  system clock; registered outputs update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable for registered outputs.
- a_val  input  WIDTH  operand A (rs1 or PC).
- b_val  input  WIDTH  operand B (rs2 or immediate).
- alu_sel  input  4  operation select.
- out_val  output  WIDTH  combinational result.
- out_q  output  WIDTH  registered result.
- zero_q  output  1  registered flag: result equal to 0.
- neg_q  output  1  registered flag: result MSB.

Behaviour:
- out_val is purely combinational. It settles within the same time step as any input change, with no dependence on clk, rst or en.
- Operation encoding of alu_sel:
  - 0 ADD: a+b, modulo 2^WIDTH, carry discarded.
  - 1 SUB: a-b, modulo 2^WIDTH.
  - 2 AND: a&b.
  - 3 OR: a|b.
  - 4 XOR: a^b.
  - 5 SLT: 1 if signed(a) < signed(b), else 0; zero-extended.
  - 6 SLTU: 1 if unsigned(a) < unsigned(b), else 0; zero-extended.
  - 7 SLL: a << b[4:0].
  - 8 SRL: logical right shift of a by b[4:0], zero fill.
  - 9 SRA: arithmetic right shift of a by b[4:0], sign fill.
  - 10 PASS_B: b (used for LUI).
  - 11-15: reserved; out_val = 0.
- Shift rules:
  - Shift amount is b_val[log2(WIDTH)-1:0] only; upper bits of b_val are ignored.
  - A shift amount of 0 returns a unchanged.
- No exceptions on overflow. Arithmetic wraps.
- Registered path:
  - On a rising clk edge with en=1: out_q <= out_val, zero_q <= (out_val==0), neg_q <= out_val[WIDTH-1].
  - With en=0 all three hold their value.
- Reset:
  - rst=1 asynchronously forces out_q=0, zero_q=1 (consistent with out_q=0), neg_q=0.
  - Reset dominates en.
  - Deassertion takes effect at the next edge.
  - Reset asserted mid-operation does not affect out_val.

Decomposition:
- Shared package (alu_pkg): alu_sel opcode constants ALU_ADD..ALU_PASS_B, and the WIDTH default.
- The control decoder in the datapath imports the same constants.
- One natural sub-module: alu_shifter, holding the SLL/SRL/SRA barrel shifter with shift direction and arithmetic-fill controls.
- The rest stays in alu: adder/subtractor, logic ops, compare, output mux and registers.

Test Plan:
- ADD: a=1, b=2, sel=0 -> out_val=3. a=-100, b=2 -> out_val=-98. a=0x7FFFFFFF, b=1 -> 0x80000000 (wrap).
- SUB/compare:
  - a=1, b=2, sel=1 -> out_val=-1 (0xFFFFFFFF).
  - SLT a=-5, b=-4 -> 1.
  - SLTU a=0xFFFFFFFF, b=1 -> 0.
  - SLTU a=1, b=0xFFFFFFFF -> 1.
- Shifts:
  - SRA a=-8, b=1 -> -4. SRA a=8, b=2 -> 2.
  - SRL a=0x80000000, b=31 -> 1.
  - SLL a=1, b=0x21 -> 2 (only b[4:0] used).
- Logic/pass/reserved: a=0xF0F0, b=0x0FF0; AND -> 0x00F0, OR -> 0xFFF0, XOR -> 0xFF00. PASS_B -> 0x0FF0. sel=15 -> 0.
- Registers: with en=1, ADD 1+2, one edge later out_q=3, zero_q=0, neg_q=0. SUB 2-2 -> zero_q=1. en=0 -> values hold.
- Reset: assert rst between edges -> out_q=0, zero_q=1, neg_q=0 immediately, with no clock needed. out_val still tracks inputs.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants for the RV32I integer ALU and its control decoder.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRL    = 4'd8;
    localparam logic [3:0] ALU_SRA    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA; direction and fill are chosen by the caller.
module alu_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a_val,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir_right,
    input  logic             arith,
    output logic [WIDTH-1:0] res
);

    logic signed [WIDTH-1:0] a_s;

    assign a_s = a_val;

    always_comb begin
        res = a_val << shamt;
        if (dir_right) begin
            if (arith) begin
                res = $unsigned(a_s >>> shamt);
            end else begin
                res = a_val >> shamt;
            end
        end
    end

endmodule

// File: rtl/alu.sv
// RV32I execute-stage ALU: combinational result plus a stage-boundary registered copy with flags.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a_val,
    input  logic [WIDTH-1:0] b_val,
    input  logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] out_val,
    output logic [WIDTH-1:0] out_q,
    output logic             zero_q,
    output logic             neg_q
);

    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic [WIDTH-1:0]        shift_res;
    logic                    dir_right;
    logic                    arith;
    logic                    lt_s;
    logic                    lt_u;

    assign a_s       = a_val;
    assign b_s       = b_val;
    assign sum       = a_val + b_val;
    assign diff      = a_val - b_val;
    assign lt_s      = a_s < b_s;
    assign lt_u      = a_val < b_val;
    assign dir_right = (alu_sel == ALU_SRL) || (alu_sel == ALU_SRA);
    assign arith     = (alu_sel == ALU_SRA);

    alu_shifter #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_shifter (
        .a_val    (a_val),
        .shamt    (b_val[SHW-1:0]),
        .dir_right(dir_right),
        .arith    (arith),
        .res      (shift_res)
    );

    always_comb begin
        out_val = '0;
        case (alu_sel)
            ALU_ADD:    out_val = sum;
            ALU_SUB:    out_val = diff;
            ALU_AND:    out_val = a_val & b_val;
            ALU_OR:     out_val = a_val | b_val;
            ALU_XOR:    out_val = a_val ^ b_val;
            ALU_SLT:    out_val = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU:   out_val = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:    out_val = shift_res;
            ALU_PASS_B: out_val = b_val;
            default:    out_val = '0;
        endcase
    end

    // Stage boundary: reset value keeps zero_q consistent with out_q = 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
        end else if (en) begin
            out_q  <= out_val;
            zero_q <= (out_val == '0);
            neg_q  <= out_val[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, randomized vectors against an arithmetic model, register and reset behaviour.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] a_val = '0;
    logic [31:0] b_val = '0;
    logic [3:0]  alu_sel = '0;
    logic [31:0] out_val;
    logic [31:0] out_q;
    logic        zero_q;
    logic        neg_q;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a_val  (a_val),
        .b_val  (b_val),
        .alu_sel(alu_sel),
        .out_val(out_val),
        .out_q  (out_q),
        .zero_q (zero_q),
        .neg_q  (neg_q)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, shifts as multiply/divide by powers of two.
    function automatic logic [31:0] model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p2;
        longint          q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p2 = 64'sd1 << b[4:0];
        case (sel)
            4'd0:  return 32'(ua + ub);
            4'd1:  return 32'(ua - ub);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd7:  return 32'(ua * longint'(p2));
            4'd8:  return 32'(ua / longint'(p2));
            4'd9: begin
                if (sa >= 0) q = sa / p2;
                else         q = -((-sa + p2 - 1) / p2);
                return 32'(q);
            end
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic comb(input string tag, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        alu_sel = sel;
        a_val   = a;
        b_val   = b;
        #1;
        chk(tag, out_val, exp);
    endtask

    initial begin
        logic [31:0] exp_q;
        logic        exp_z;
        logic        exp_n;
        logic [31:0] v;

        // Reset state with no clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_out_q", out_q, 32'd0);
        chk("rst_zero_q", 32'(zero_q), 32'd1);
        chk("rst_neg_q", 32'(neg_q), 32'd0);

        comb("add_1_2", 4'd0, 32'd1, 32'd2, 32'd3);
        comb("add_neg", 4'd0, 32'hFFFF_FF9C, 32'd2, 32'hFFFF_FF9E);
        comb("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        comb("sub_1_2", 4'd1, 32'd1, 32'd2, 32'hFFFF_FFFF);
        comb("slt_m5_m4", 4'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 32'd1);
        comb("sltu_big_1", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0);
        comb("sltu_1_big", 4'd6, 32'd1, 32'hFFFF_FFFF, 32'd1);
        comb("sra_m8_1", 4'd9, 32'hFFFF_FFF8, 32'd1, 32'hFFFF_FFFC);
        comb("sra_8_2", 4'd9, 32'd8, 32'd2, 32'd2);
        comb("srl_msb_31", 4'd8, 32'h8000_0000, 32'd31, 32'd1);
        comb("sll_1_x21", 4'd7, 32'd1, 32'h21, 32'd2);
        comb("sll_amt0", 4'd7, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF);
        comb("sra_amt0", 4'd9, 32'h8000_0001, 32'd0, 32'h8000_0001);
        comb("and", 4'd2, 32'hF0F0, 32'h0FF0, 32'h00F0);
        comb("or", 4'd3, 32'hF0F0, 32'h0FF0, 32'hFFF0);
        comb("xor", 4'd4, 32'hF0F0, 32'h0FF0, 32'hFF00);
        comb("pass_b", 4'd10, 32'hF0F0, 32'h0FF0, 32'h0FF0);
        comb("rsvd_15", 4'd15, 32'hF0F0, 32'h0FF0, 32'd0);
        comb("rsvd_11", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

        // Reset held through edges dominates en
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_dom_out_q", out_q, 32'd0);
        chk("rst_dom_zero_q", 32'(zero_q), 32'd1);

        @(negedge clk);
        rst = 1'b0;
        comb("reg_add_comb", 4'd0, 32'd1, 32'd2, 32'd3);
        @(posedge clk);
        #1;
        chk("reg_add_out_q", out_q, 32'd3);
        chk("reg_add_zero_q", 32'(zero_q), 32'd0);
        chk("reg_add_neg_q", 32'(neg_q), 32'd0);

        comb("reg_sub0_comb", 4'd1, 32'd2, 32'd2, 32'd0);
        @(posedge clk);
        #1;
        chk("reg_sub0_out_q", out_q, 32'd0);
        chk("reg_sub0_zero_q", 32'(zero_q), 32'd1);

        comb("reg_neg_comb", 4'd1, 32'd1, 32'd2, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        chk("reg_neg_out_q", out_q, 32'hFFFF_FFFF);
        chk("reg_neg_neg_q", 32'(neg_q), 32'd1);
        chk("reg_neg_zero_q", 32'(zero_q), 32'd0);

        en = 1'b0;
        comb("hold_comb", 4'd0, 32'd5, 32'd6, 32'd11);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("hold_out_q", out_q, 32'hFFFF_FFFF);
        chk("hold_neg_q", 32'(neg_q), 32'd1);
        chk("hold_zero_q", 32'(zero_q), 32'd0);

        // Asynchronous reset between edges; out_val keeps tracking inputs
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_out_q", out_q, 32'd0);
        chk("async_zero_q", 32'(zero_q), 32'd1);
        chk("async_neg_q", 32'(neg_q), 32'd0);
        comb("rst_comb_track", 4'd4, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678);
        @(negedge clk);
        rst = 1'b0;

        // Randomized vectors through both paths
        exp_q = out_q === 32'd0 ? 32'd0 : 32'hX;
        exp_q = 32'd0;
        exp_z = 1'b1;
        exp_n = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            alu_sel = 4'($urandom_range(0, 15));
            a_val   = $urandom;
            b_val   = (i % 4 == 0) ? a_val : $urandom;
            en      = 1'($urandom_range(0, 1));
            #1;
            v = model(alu_sel, a_val, b_val);
            chk("rand_comb", out_val, v);
            if (en) begin
                exp_q = v;
                exp_z = (v == 32'd0);
                exp_n = v[31];
            end
            @(posedge clk);
            #1;
            chk("rand_out_q", out_q, exp_q);
            chk("rand_zero_q", 32'(zero_q), 32'(exp_z));
            chk("rand_neg_q", 32'(neg_q), 32'(exp_n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
